pool2d_multichannel_with_mem: RTL
=================================

Name: pool2d_multichannel_with_mem

Overview:
Parametrised successor to the single-channel 2x2 max-pool engine. It pools a stack of CHANNELS feature maps (HEIGHT x WIDTH each, channel-major in shared memory) with configurable window and stride, in max or average mode selected per run. It shares the memory bus (address_bus / data_bus / mem_sel / mem_w / ready) with the other near-memory compute blocks and processes one channel at a time through a local buffer.

Parameters:
DATA_WIDTH, 8, element width in bits
ADDR_WIDTH, 8, memory address width
DATABUS_WIDTH, 32, memory data bus width (>= DATA_WIDTH)
HEIGHT, 4, input rows per channel
WIDTH, 4, input columns per channel
CHANNELS, 2, number of channels (>= 1)
POOL_SIZE, 2, square window side; power of two, <= HEIGHT and <= WIDTH
STRIDE, 2, window step (>= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
mode  input  1  0 = max, 1 = average; latched at start
done  output  1  one-cycle pulse when the run completes
busy  output  1  high from the cycle after an accepted start until done
input_addr  input  ADDR_WIDTH  base of channel 0 input; latched at start
output_addr  input  ADDR_WIDTH  base of channel 0 output; latched at start
mem_w  output  1  1 = write access
mem_sel  output  1  bus request; when 0, address_bus and data_bus are high-Z
address_bus  inout  ADDR_WIDTH  driven when mem_sel = 1
data_bus  inout  DATABUS_WIDTH  driven when mem_sel = 1 and mem_w = 1
ready  input  1  memory completes the current access

Behaviour:
- Reset (asynchronous, any state, including mid-access): state IDLE; done, busy, mem_sel, mem_w = 0; counters, latched address/data registers and accumulator = 0; buses released at once.
- OUT_H = (HEIGHT-POOL_SIZE)/STRIDE+1, OUT_W = (WIDTH-POOL_SIZE)/STRIDE+1.
- Layout: input element (c,r,k) at input_addr + c*HEIGHT*WIDTH + r*WIDTH + k. Output element (c,oy,ox) at output_addr + c*OUT_H*OUT_W + oy*OUT_W + ox. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Bus access: the engine asserts mem_sel (and mem_w for writes) with the address and data registered. It holds them until ready is sampled high. In that same edge it captures a read (data_bus[DATA_WIDTH-1:0]) and drops mem_sel and mem_w. It then spends exactly one stall cycle with mem_sel = 0 before the next access. ready is ignored while mem_sel = 0.
- Writes drive data_bus = zero-extended result.
- FSM:
  - IDLE: if start, latch mode and the two addresses, set c=0, go LOAD. start while busy is ignored.
  - LOAD: read HEIGHT*WIDTH elements of channel c in row-major order into the local buffer, then go INIT.
  - INIT: clear the window counters pi, pj to 0. Set acc to the first element (max) or 0 (avg). Go ACCUM.
  - ACCUM: one element per cycle, at input position (oy*STRIDE+pi, ox*STRIDE+pj). Takes POOL_SIZE^2 cycles, then go WRITE.
  - WRITE: one bus write of the result, then go NEXT.
  - NEXT:
    - ox++ (stay inside the current channel).
    - At OUT_W-1: ox=0, oy++.
    - At OUT_H-1: oy=0, c++, go LOAD.
    - At the last channel: go DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Arithmetic:
  - Max: unsigned compare, and ties keep the current value.
  - Avg: sum in DATA_WIDTH+2*log2(POOL_SIZE) bits, then result = sum >> (2*log2(POOL_SIZE)), truncating toward zero. No overflow is possible.
- Windows never exceed the input bounds by construction. Leftover rows and columns (when (HEIGHT-POOL_SIZE) is not a multiple of STRIDE) are not read by any window.
- ready held high permanently: each access then takes 1 cycle plus 1 stall cycle.
- mode, input_addr and output_addr changes during a run have no effect.

Optional Feature:
POOL_SIGNED_EN:
- Defined: elements are two's complement. Max uses a signed compare. Avg sign-extends into the accumulator, uses an arithmetic right shift (floor), and sign-extends the result to DATABUS_WIDTH on write.
- Undefined: unsigned behaviour as above, zero-extended writes.

Test Plan:
1. Defaults, mode=0, ready tied high. Ch0 = 1..16, ch1 = 16..1, input_addr=0x00, output_addr=0x40. Required: 0x40..0x43 = 6,8,14,16; 0x44..0x47 = 16,14,8,6; exactly one done pulse; 32 reads and 8 writes.
2. Same data, mode=1. Required: ch0 = 3,5,11,13 (truncated); ch1 = 13,11,5,3.
3. ready delayed 3 cycles per access. Required: mem_sel held until ready; a one-cycle mem_sel=0 gap after every access; results identical to case 1.
4. HEIGHT=WIDTH=5, STRIDE=1, CHANNELS=1, max mode, data = 0..24 row-major. Required: 16 outputs, output(oy,ox) = 5*oy+ox+6; the last write goes to output_addr+15.
5. rst pulsed mid-LOAD (asynchronous, between clocks). Required: mem_sel=0 and buses high-Z immediately, busy=0. A new start reruns case 1 correctly.
6. With POOL_SIGNED_EN: window {-3,-1,-8,-2}. Required: max=-1 (0xFFFFFFFF on the bus); avg=-4 (floor of -14/4).

Source files
------------

// File: rtl/pool2d_multichannel_with_mem_if.sv
// rtl/pool2d_multichannel_with_mem_if.sv - run-control handshake between a host and the pooling engine
interface pool2d_multichannel_with_mem_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  mode;
  logic                  done;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic [ADDR_WIDTH-1:0] output_addr;

  modport master (output start, mode, input_addr, output_addr, input done, busy);
  modport slave  (input start, mode, input_addr, output_addr, output done, busy);
endinterface

// File: rtl/pool2d_multichannel_with_mem.sv
// rtl/pool2d_multichannel_with_mem.sv - multichannel max/avg 2D pooling over a shared memory bus
// Optional POOL_SIGNED_EN: two's complement elements (signed max, floor average, sign-extended writes).
module pool2d_multichannel_with_mem #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int HEIGHT        = 4,
  parameter int WIDTH         = 4,
  parameter int CHANNELS      = 2,
  parameter int POOL_SIZE     = 2,
  parameter int STRIDE        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pool2d_multichannel_with_mem_if.slave ctrl,
  output logic                     mem_w,
  output logic                     mem_sel,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                     ready
);
  localparam int OUT_H = (HEIGHT - POOL_SIZE) / STRIDE + 1;
  localparam int OUT_W = (WIDTH - POOL_SIZE) / STRIDE + 1;
  localparam int N_IN  = HEIGHT * WIDTH;
  localparam int N_OUT = OUT_H * OUT_W;
  localparam int SHIFT = 2 * $clog2(POOL_SIZE);
  localparam int ACC_W = DATA_WIDTH + SHIFT;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_ACCUM, S_WRITE, S_NEXT, S_DONE} state_t;

  state_t                   state;
  logic                     mode_q, done_q, busy_q, stall;
  logic [ADDR_WIDTH-1:0]    in_base, out_base, addr_q;
  logic [DATABUS_WIDTH-1:0] wdata_q;
  logic [31:0]              c, oy, ox, pi, pj, idx;
  logic [ACC_W-1:0]         acc;
  logic [DATA_WIDTH-1:0]    lbuf [N_IN];

  logic [DATA_WIDTH-1:0]    elem, first_elem, avg_q, result;
  logic [ACC_W-1:0]         elem_ext;
  logic [DATABUS_WIDTH-1:0] wr_ext;
  logic                     take;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  wire                      unused_bus = ^data_bus;

  assign ctrl.done   = done_q;
  assign ctrl.busy   = busy_q;
  assign address_bus = mem_sel ? addr_q : 'z;
  assign data_bus    = (mem_sel && mem_w) ? wdata_q : 'z;

  assign elem       = lbuf[IDX_W'((oy * STRIDE + pi) * WIDTH + ox * STRIDE + pj)];
  assign first_elem = lbuf[IDX_W'(oy * STRIDE * WIDTH + ox * STRIDE)];

`ifdef POOL_SIGNED_EN
  assign elem_ext = ACC_W'($signed(elem));
  assign take     = $signed(elem) > $signed(acc[DATA_WIDTH-1:0]);
  assign avg_q    = DATA_WIDTH'($signed(acc) >>> SHIFT);
  assign wr_ext   = DATABUS_WIDTH'($signed(result));
`else
  assign elem_ext = ACC_W'(elem);
  assign take     = elem > acc[DATA_WIDTH-1:0];
  assign avg_q    = DATA_WIDTH'(acc >> SHIFT);
  assign wr_ext   = DATABUS_WIDTH'(result);
`endif
  assign result  = mode_q ? avg_q : acc[DATA_WIDTH-1:0];
  assign wr_addr = ADDR_WIDTH'(32'(out_base) + c * N_OUT + oy * OUT_W + ox);

  function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [31:0] k);
    return ADDR_WIDTH'(32'(in_base) + c * N_IN + k);
  endfunction

  always_ff @(posedge clk) begin
    if (state == S_LOAD && mem_sel && ready) lbuf[IDX_W'(idx)] <= data_bus[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;  mode_q <= 1'b0;  done_q <= 1'b0;  busy_q <= 1'b0;
      stall <= 1'b0;    mem_sel <= 1'b0; mem_w <= 1'b0;
      in_base <= '0;    out_base <= '0;  addr_q <= '0;    wdata_q <= '0;
      c <= '0; oy <= '0; ox <= '0; pi <= '0; pj <= '0; idx <= '0; acc <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (ctrl.start) begin
          mode_q   <= ctrl.mode;
          in_base  <= ctrl.input_addr;
          out_base <= ctrl.output_addr;
          c <= '0; oy <= '0; ox <= '0; idx <= '0;
          busy_q <= 1'b1;
          state  <= S_LOAD;
        end
        // Stall cycle issues the next read directly so the bus gap is exactly one cycle.
        S_LOAD: if (mem_sel) begin
          if (ready) begin mem_sel <= 1'b0; stall <= 1'b1; end
        end else if (stall) begin
          stall <= 1'b0;
          if (idx == N_IN - 1) begin
            idx <= '0;
            state <= S_INIT;
          end else begin
            idx <= idx + 32'd1;
            mem_sel <= 1'b1;
            addr_q <= rd_addr(idx + 32'd1);
          end
        end else begin
          mem_sel <= 1'b1;
          addr_q <= rd_addr(idx);
        end
        S_INIT: begin
          pi <= '0; pj <= '0;
          acc <= mode_q ? '0 : ACC_W'(first_elem);
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (mode_q) acc <= acc + elem_ext;
          else if (take) acc <= ACC_W'(elem);
          if (pj == POOL_SIZE - 1) begin
            pj <= '0;
            if (pi == POOL_SIZE - 1) begin pi <= '0; state <= S_WRITE; end
            else pi <= pi + 32'd1;
          end else pj <= pj + 32'd1;
        end
        S_WRITE: if (mem_sel) begin
          if (ready) begin mem_sel <= 1'b0; mem_w <= 1'b0; stall <= 1'b1; end
        end else if (stall) begin
          stall <= 1'b0;
          state <= S_NEXT;
        end else begin
          mem_sel <= 1'b1; mem_w <= 1'b1;
          addr_q <= wr_addr; wdata_q <= wr_ext;
        end
        S_NEXT: if (ox == OUT_W - 1) begin
          ox <= '0;
          if (oy == OUT_H - 1) begin
            oy <= '0;
            if (c == CHANNELS - 1) state <= S_DONE;
            else begin c <= c + 32'd1; state <= S_LOAD; end
          end else begin oy <= oy + 32'd1; state <= S_INIT; end
        end else begin ox <= ox + 32'd1; state <= S_INIT; end
        S_DONE: begin
          done_q <= 1'b1; busy_q <= 1'b0; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
